video_timing_sequencer: RTL and testbench

// - Sequences the terminal's cascaded character/line counters: generates character column, text row
//   and scan-line indices, hsync/vsync, blanking and line/frame strobes for the character ROM and video path.
// - Advances only on a one-clock character-period enable, the same role as the CEP/CET chain enables of a

---
 rtl/video_timing_sequencer.sv | 143 ++++++++++++++
 tb/tb_video_timing_sequencer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/video_timing_sequencer.sv
// video_timing_sequencer: cascaded character/line counters, syncs, blanking and scroll for a text terminal
// Optional feature macro: CURSOR_BLINK_EN (cursor blink frame counter; undefined => cursor_on tied to 1)
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   char_tick           character-period enable; all counting happens only on ticked edges
//   scroll_req/ack      level request to advance row base at the next frame wrap / one-clock acknowledge
//   char_col            horizontal character count
//   char_row, scan_line text row (scrolled by row base) and scan line within it, 0 outside visible lines
//   hsync, vsync, blank active-high sync and blanking levels
//   line_end, frame_end one-clock strobes on the clock after an h / v wrap
//   cursor_on           cursor visibility
module video_timing_sequencer #(
    parameter int H_VIS         = 40,
    parameter int H_TOTAL       = 65,
    parameter int HSYNC_START   = 46,
    parameter int HSYNC_LEN     = 4,
    parameter int LINES_PER_ROW = 8,
    parameter int ROWS          = 24,
    parameter int V_TOTAL       = 262,
    parameter int VSYNC_START   = 224,
    parameter int VSYNC_LEN     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       char_tick,
    input  logic       scroll_req,
    output logic       scroll_ack,
    output logic [6:0] char_col,
    output logic [4:0] char_row,
    output logic [3:0] scan_line,
    output logic       hsync,
    output logic       vsync,
    output logic       blank,
    output logic       line_end,
    output logic       frame_end,
    output logic       cursor_on
);
    localparam logic [6:0] H_LAST  = 7'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST  = 9'(V_TOTAL - 1);
    localparam logic [6:0] H_VIS_C = 7'(H_VIS);
    localparam logic [8:0] V_VIS_C = 9'(ROWS * LINES_PER_ROW);
    localparam logic [7:0] HS_BEG  = 8'(HSYNC_START);
    localparam logic [7:0] HS_END  = 8'(HSYNC_START + HSYNC_LEN);
    localparam logic [9:0] VS_BEG  = 10'(VSYNC_START);
    localparam logic [9:0] VS_END  = 10'(VSYNC_START + VSYNC_LEN);
    localparam logic [3:0] SCAN_LAST = 4'(LINES_PER_ROW - 1);
    localparam logic [4:0] ROW_LAST  = 5'(ROWS - 1);
    localparam logic [5:0] ROWS_C    = 6'(ROWS);

    logic [6:0] h_q, h_d;
    logic [8:0] v_q, v_d;
    logic [3:0] scan_q, scan_d;
    logic [4:0] trow_q, trow_d;
    logic [4:0] rb_q, rb_d;
    logic [4:0] char_row_q, char_row_d;
    logic       hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d;
    logic       line_end_q, frame_end_q, scroll_ack_q;
    logic       h_wrap, v_wrap, v_vis, take;
    logic [5:0] sum;

    always_comb begin
        h_wrap  = char_tick && (h_q == H_LAST);
        v_wrap  = h_wrap && (v_q == V_LAST);
        h_d     = !char_tick ? h_q : (h_wrap ? 7'd0 : h_q + 7'd1);
        v_d     = !h_wrap ? v_q : (v_wrap ? 9'd0 : v_q + 9'd1);
        v_vis   = v_d < V_VIS_C;
        // scan/text-row cascade: cleared on frame wrap and for every invisible line
        scan_d  = !h_wrap ? scan_q : ((v_wrap || !v_vis || scan_q == SCAN_LAST) ? 4'd0 : scan_q + 4'd1);
        trow_d  = !h_wrap ? trow_q : ((v_wrap || !v_vis) ? 5'd0 : (scan_q == SCAN_LAST ? trow_q + 5'd1 : trow_q));
        take    = v_wrap && scroll_req;
        rb_d    = !take ? rb_q : (rb_q == ROW_LAST ? 5'd0 : rb_q + 5'd1);
        // new row base is already applied to row 0 of the frame it is taken for
        sum        = {1'b0, trow_d} + {1'b0, rb_d};
        char_row_d = !v_vis ? 5'd0 : (sum >= ROWS_C ? 5'(sum - ROWS_C) : sum[4:0]);
        hsync_d    = ({1'b0, h_d} >= HS_BEG) && ({1'b0, h_d} < HS_END);
        vsync_d    = ({1'b0, v_d} >= VS_BEG) && ({1'b0, v_d} < VS_END);
        blank_d    = (h_d >= H_VIS_C) || !v_vis;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q          <= '0;
            v_q          <= '0;
            scan_q       <= '0;
            trow_q       <= '0;
            rb_q         <= '0;
            char_row_q   <= '0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            blank_q      <= 1'b0;
            line_end_q   <= 1'b0;
            frame_end_q  <= 1'b0;
            scroll_ack_q <= 1'b0;
        end else begin
            h_q          <= h_d;
            v_q          <= v_d;
            scan_q       <= scan_d;
            trow_q       <= trow_d;
            rb_q         <= rb_d;
            char_row_q   <= char_row_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            blank_q      <= blank_d;
            line_end_q   <= h_wrap;
            frame_end_q  <= v_wrap;
            scroll_ack_q <= take;
        end
    end

`ifdef CURSOR_BLINK_EN
    logic [4:0] fc_q, fc_d;
    logic       cursor_q, cursor_d;

    always_comb begin
        fc_d     = !v_wrap ? fc_q : (fc_q == 5'd29 ? 5'd0 : fc_q + 5'd1);
        cursor_d = (v_wrap && fc_q == 5'd29) ? !cursor_q : cursor_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fc_q     <= '0;
            cursor_q <= 1'b1;
        end else begin
            fc_q     <= fc_d;
            cursor_q <= cursor_d;
        end
    end

    assign cursor_on = cursor_q;
`else
    assign cursor_on = 1'b1;
`endif

    assign char_col   = h_q;
    assign char_row   = char_row_q;
    assign scan_line  = scan_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign blank      = blank_q;
    assign line_end   = line_end_q;
    assign frame_end  = frame_end_q;
    assign scroll_ack = scroll_ack_q;
endmodule

// File: tb/tb_video_timing_sequencer.sv
// tb_video_timing_sequencer: scoreboard bench for a default-size and a tiny-size video_timing_sequencer
module tb_video_timing_sequencer;
    typedef struct {int hv, ht, hs, hl, lpr, rows, vt, vs, vl;} cfg_t;

    logic       clk = 1'b0, rst = 1'b1, char_tick = 1'b0, scroll_req = 1'b0;
    logic [6:0] col[2];
    logic [4:0] row[2];
    logic [3:0] scan[2];
    logic       hs[2], vs[2], bl[2], le[2], fe[2], ack[2], cur[2];

    cfg_t cfg[2];
    int   mh[2], mv[2], mrb[2], mfc[2];
    bit   mcur[2];
    logic [22:0] sb0[$], sb1[$];
    int   vectors = 0, errors = 0;

    always #5 clk = ~clk;

    video_timing_sequencer u0 (
        .clk(clk), .rst(rst), .char_tick(char_tick), .scroll_req(scroll_req), .scroll_ack(ack[0]),
        .char_col(col[0]), .char_row(row[0]), .scan_line(scan[0]), .hsync(hs[0]), .vsync(vs[0]),
        .blank(bl[0]), .line_end(le[0]), .frame_end(fe[0]), .cursor_on(cur[0]));

    video_timing_sequencer #(
        .H_VIS(4), .H_TOTAL(8), .HSYNC_START(5), .HSYNC_LEN(2), .LINES_PER_ROW(2), .ROWS(3),
        .V_TOTAL(8), .VSYNC_START(6), .VSYNC_LEN(1)
    ) u1 (
        .clk(clk), .rst(rst), .char_tick(char_tick), .scroll_req(scroll_req), .scroll_ack(ack[1]),
        .char_col(col[1]), .char_row(row[1]), .scan_line(scan[1]), .hsync(hs[1]), .vsync(vs[1]),
        .blank(bl[1]), .line_end(le[1]), .frame_end(fe[1]), .cursor_on(cur[1]));

    task automatic check(input string tag, input logic [22:0] obs, input logic [22:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [22:0] observed(int i);
        return {col[i], row[i], scan[i], hs[i], vs[i], bl[i], le[i], fe[i], ack[i], cur[i]};
    endfunction

    // expected outputs from the model state; row/scan derived by division on purpose
    function automatic logic [22:0] exp_vec(int i, bit l, bit f, bit a);
        int h = mh[i];
        int v = mv[i];
        bit vis = v < cfg[i].rows * cfg[i].lpr;
        int r = vis ? (v / cfg[i].lpr + mrb[i]) % cfg[i].rows : 0;
        int s = vis ? v % cfg[i].lpr : 0;
        bit h_s = h >= cfg[i].hs && h < cfg[i].hs + cfg[i].hl;
        bit v_s = v >= cfg[i].vs && v < cfg[i].vs + cfg[i].vl;
        bit b = h >= cfg[i].hv || !vis;
        return {7'(h), 5'(r), 4'(s), h_s, v_s, b, l, f, a, mcur[i]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mh[i] = 0; mv[i] = 0; mrb[i] = 0; mfc[i] = 0; mcur[i] = 1'b1;
        end
        sb0.delete();
        sb1.delete();
    endtask

    task automatic model_step(input int i, input bit tick, input bit req);
        bit hw, vw, a;
        hw = tick && mh[i] == cfg[i].ht - 1;
        vw = hw && mv[i] == cfg[i].vt - 1;
        a  = vw && req;
        if (a) mrb[i] = (mrb[i] == cfg[i].rows - 1) ? 0 : mrb[i] + 1;
`ifdef CURSOR_BLINK_EN
        if (vw) begin
            if (mfc[i] == 29) begin mfc[i] = 0; mcur[i] = !mcur[i]; end
            else mfc[i]++;
        end
`endif
        if (tick) mh[i] = hw ? 0 : mh[i] + 1;
        if (hw) mv[i] = vw ? 0 : mv[i] + 1;
        if (i == 0) sb0.push_back(exp_vec(i, hw, vw, a));
        else sb1.push_back(exp_vec(i, hw, vw, a));
    endtask

    task automatic cycle(input bit tick, input bit req);
        char_tick  = tick;
        scroll_req = req;
        model_step(0, tick, req);
        model_step(1, tick, req);
        @(posedge clk);
        #1;
        check("u0", observed(0), sb0.pop_front());
        check("u1", observed(1), sb1.pop_front());
    endtask

    task automatic check_reset();
        check("rst_u0", observed(0), exp_vec(0, 0, 0, 0));
        check("rst_u1", observed(1), exp_vec(1, 0, 0, 0));
    endtask

    initial begin
        cfg[0] = '{hv: 40, ht: 65, hs: 46, hl: 4, lpr: 8, rows: 24, vt: 262, vs: 224, vl: 3};
        cfg[1] = '{hv: 4, ht: 8, hs: 5, hl: 2, lpr: 2, rows: 3, vt: 8, vs: 6, vl: 1};
        model_reset();
        #12;
        check_reset();
        rst = 1'b0;
        // two full lines ticking every clock: line_end after 65 and 130 ticks
        for (int n = 0; n < 140; n++) cycle(1'b1, 1'b0);
        // tick every third clock: counts hold between ticks, strobes stay one clock
        for (int n = 0; n < 600; n++) cycle(n % 3 == 2, 1'b0);
        // run to h=20, v=100 then reset mid-line, away from any clock edge
        for (int n = 0; n < 20000 && !(mh[0] == 20 && mv[0] == 100); n++) cycle(1'b1, 1'b0);
        check("mid_h", 32'(col[0]), 32'd20);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_reset();
        #2;
        rst = 1'b0;
        // full frame without scroll: blanking, vsync, frame_end and row/scan cascade
        for (int n = 0; n < 17100; n++) cycle(1'b1, 1'b0);
        // scroll held across two frame wraps of u0 (many for u1, exercising row base wrap)
        for (int n = 0; n < 34100; n++) cycle(1'b1, 1'b1);
        // request toggling and irregular ticks: drops before the wrap must not scroll
        for (int n = 0; n < 4000; n++) cycle($urandom_range(0, 3) != 0, (n / 11) % 2 == 1 && $urandom_range(0, 1) == 1);
        for (int n = 0; n < 300; n++) cycle(1'b0, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
